filter_arbiter: RTL and testbench
=================================

Name: filter_arbiter

Overview:
- Sits directly downstream of a group of NUM_FILTER filter-logic instances; feeds a single force pipeline.
- Each filter owns a buffer of particle pairs that passed the cutoff test.
- Each cycle, the block picks at most one non-empty filter in round-robin order and pulses that filter's read-select.
- It captures the buffer output one cycle later and presents one registered pair plus a valid strobe to the force pipeline.

Parameters:
- DATA_WIDTH, 32: float word width of r2/dx/dy/dz.
- PARTICLE_ID_WIDTH, 20: width of each particle ID.
- NUM_FILTER, 4: number of filters arbitrated (2..8).
- FILTER_SEL_WIDTH, 2: index width, log2(NUM_FILTER).
- COUNT_WIDTH, 32: width of the granted-pair counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- particle_pair_available  in  NUM_FILTER  bit i = filter i buffer non-empty.
- sel  out  NUM_FILTER  one-hot read request to filter i; combinational.
- ref_particle_id_in  in  NUM_FILTER*PARTICLE_ID_WIDTH  filter i output in slice i.
- neighbor_particle_id_in  in  NUM_FILTER*PARTICLE_ID_WIDTH  filter i output in slice i.
- r2_in, dx_in, dy_in, dz_in  in  NUM_FILTER*DATA_WIDTH each  filter i outputs in slice i.
- out_stall  in  1  force pipeline cannot accept new grants.
- ref_particle_id_out  out  PARTICLE_ID_WIDTH  registered selected pair.
- neighbor_particle_id_out  out  PARTICLE_ID_WIDTH  registered selected pair.
- r2, dx, dy, dz  out  DATA_WIDTH each  registered selected pair.
- out_valid  out  1  output pair valid this cycle.
- out_filter_id  out  FILTER_SEL_WIDTH  source filter of the current output.
- pair_count  out  COUNT_WIDTH  total grants since reset.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0; sel=0 while in reset.
  - last_grant = NUM_FILTER-1, so filter 0 has first priority.
  - Pipeline valid flags cleared. Any read issued before reset is discarded.
- Grant (combinational, cycle T):
  - If out_stall=0 and any available bit is set, sel is one-hot on the first set bit scanning last_grant+1, +2, …, wrapping modulo NUM_FILTER.
  - Otherwise sel=0.
  - sel is never asserted for a filter whose available bit is 0 (no underflow).
- Registered state at the end of T, on a grant:
  - last_grant <= granted index.
  - stage1_valid <= 1; stage1_idx <= granted index.
  - pair_count <= pair_count+1, wrapping at 2^COUNT_WIDTH.
  - With no grant: stage1_valid <= 0; last_grant holds.
- Data capture:
  - Buffer read latency is 1 cycle: q is valid in T+1.
  - At the end of T+1, output registers load slice stage1_idx of every *_in bus.
  - out_valid <= stage1_valid; out_filter_id <= stage1_idx.
- Latency: sel in cycle T -> out_valid=1 in cycle T+2. Throughput is 1 pair/cycle.
- When out_valid=0, data outputs hold their last value.
- Stall:
  - out_stall only blocks new grants.
  - Up to 2 already-issued pairs still emerge; the force pipeline must absorb 2 after raising stall.
- Available bit semantics:
  - Filter buffers update the available bit one cycle after a read.
  - A filter with one entry granted in T may show available=1 in T+1 only if it really holds another entry. The block relies on the buffer's empty flag being exact at each clock edge.
- Fairness: with all filters continuously available, grants cycle 0,1,…,NUM_FILTER-1,0,…; no filter waits more than NUM_FILTER-1 grants.
- Reset mid-operation: in-flight stage1/output valid drop to 0 immediately; no partial pair is emitted after reset release.

Decomposition:
- Shared package:
  - Pair bundle width constant PAIR_WIDTH = 2*PARTICLE_ID_WIDTH + 4*DATA_WIDTH.
  - Field ordering {ref_id, neighbor_id, r2, dz, dy, dx}.
  - Default NUM_FILTER / FILTER_SEL_WIDTH.
- One sub-module: rr_priority_select. Combinational round-robin pick from a request vector and last-grant index; outputs one-hot grant, grant index, and any_grant.

Test Plan:
- Only filter 2 available, one entry (avail=0100 for 1 cycle, then 0000) -> sel=0100 once; out_valid one cycle 2 later with filter 2's data; out_filter_id=2; pair_count=1.
- All four filters always available, 8 cycles -> sel order 0001,0010,0100,1000,0001,…; out_filter_id 0,1,2,3,0,… from cycle 2; pair_count=8.
- avail=1010 constant after reset -> grants alternate 1,3,1,3; filters 0 and 2 never selected.
- All available, out_stall=1 in cycles 3–5 -> sel=0 in 3–5; out_valid drops exactly in cycles 5–7; round-robin resumes at the next index after the last grant.
- Assert rst=0 asynchronously while out_valid=1 and stage1 full -> outputs and sel go to 0 without waiting for a clock. After release with avail=1111 -> first grant is filter 0.
- Preload pair_count near 2^COUNT_WIDTH-1 (COUNT_WIDTH=4 build, 17 grants) -> wraps to 1; no effect on grant order.

Source files
------------

// File: rtl/filter_arbiter_pkg.sv
// Shared constants for the filter arbiter: default geometry and the layout of
// the selected-pair bundle {ref_id, neighbor_id, r2, dz, dy, dx} (dx in the LSBs).
package filter_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEF        = 32;
  localparam int unsigned PARTICLE_ID_WIDTH_DEF = 20;
  localparam int unsigned NUM_FILTER_DEF        = 4;
  localparam int unsigned FILTER_SEL_WIDTH_DEF  = 2;
  localparam int unsigned COUNT_WIDTH_DEF       = 32;

  localparam int unsigned PAIR_WIDTH = 2 * PARTICLE_ID_WIDTH_DEF + 4 * DATA_WIDTH_DEF;

  // Pair bundle width for an arbitrary ID/data geometry.
  function automatic int unsigned pair_width(input int unsigned id_w, input int unsigned data_w);
    return 2 * id_w + 4 * data_w;
  endfunction

endpackage

// File: rtl/filter_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first set request bit scanning
// last_grant+1, last_grant+2, ... modulo N.
// Ports: req (request vector), last_grant (index granted most recently),
//        grant (one-hot), grant_idx (index of grant), any_grant.
module rr_priority_select #(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [SEL_W-1:0] cand;

  // Offset 1 is scanned first; offset N wraps back onto last_grant itself.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = SEL_W'((32'(last_grant) + i) % N);
      if (!any_grant && req[cand]) begin
        any_grant   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/filter_arbiter.sv
// Round-robin arbiter between NUM_FILTER pair buffers and one force pipeline.
// Pulses a one-hot read select, captures the buffer output one cycle later and
// presents a registered pair with a valid strobe two cycles after the select.
// Ports:
//   clk, rst (async, active-low)
//   particle_pair_available  per-filter non-empty flags
//   sel                      one-hot read select (combinational)
//   *_in                     per-filter buffer outputs, filter i in slice i
//   out_stall                blocks new grants only
//   ref/neighbor_particle_id_out, r2, dx, dy, dz  registered selected pair
//   out_valid, out_filter_id  pair strobe and source filter
//   pair_count               grants since reset (wraps)
module filter_arbiter
  import filter_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int unsigned PARTICLE_ID_WIDTH = PARTICLE_ID_WIDTH_DEF,
  parameter int unsigned NUM_FILTER        = NUM_FILTER_DEF,
  parameter int unsigned FILTER_SEL_WIDTH  = FILTER_SEL_WIDTH_DEF,
  parameter int unsigned COUNT_WIDTH       = COUNT_WIDTH_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_FILTER-1:0]                   particle_pair_available,
  output logic [NUM_FILTER-1:0]                   sel,
  input  logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0] ref_particle_id_in,
  input  logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0] neighbor_particle_id_in,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0]        r2_in,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0]        dx_in,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0]        dy_in,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0]        dz_in,
  input  logic                                    out_stall,
  output logic [PARTICLE_ID_WIDTH-1:0]            ref_particle_id_out,
  output logic [PARTICLE_ID_WIDTH-1:0]            neighbor_particle_id_out,
  output logic [DATA_WIDTH-1:0]                   r2,
  output logic [DATA_WIDTH-1:0]                   dx,
  output logic [DATA_WIDTH-1:0]                   dy,
  output logic [DATA_WIDTH-1:0]                   dz,
  output logic                                    out_valid,
  output logic [FILTER_SEL_WIDTH-1:0]             out_filter_id,
  output logic [COUNT_WIDTH-1:0]                  pair_count
);

  localparam int unsigned PAIR_W  = pair_width(PARTICLE_ID_WIDTH, DATA_WIDTH);
  localparam int unsigned SLOTS   = 2 ** FILTER_SEL_WIDTH;
  localparam int unsigned DY_LSB  = DATA_WIDTH;
  localparam int unsigned DZ_LSB  = 2 * DATA_WIDTH;
  localparam int unsigned R2_LSB  = 3 * DATA_WIDTH;
  localparam int unsigned NBR_LSB = 4 * DATA_WIDTH;
  localparam int unsigned REF_LSB = 4 * DATA_WIDTH + PARTICLE_ID_WIDTH;

  logic [NUM_FILTER-1:0]       req_c;
  logic [NUM_FILTER-1:0]       grant_oh;
  logic [FILTER_SEL_WIDTH-1:0] grant_idx;
  logic                        any_grant;
  logic                        grant_c;
  logic [FILTER_SEL_WIDTH-1:0] last_grant;
  logic                        stage1_valid;
  logic [FILTER_SEL_WIDTH-1:0] stage1_idx;
  logic [PAIR_W-1:0]           pair_slot [SLOTS];
  logic [PAIR_W-1:0]           pair_q;

  // Stall blocks new grants only; in-flight reads still drain.
  assign req_c = out_stall ? '0 : particle_pair_available;

  rr_priority_select #(
    .N     (NUM_FILTER),
    .SEL_W (FILTER_SEL_WIDTH)
  ) u_rr (
    .req        (req_c),
    .last_grant (last_grant),
    .grant      (grant_oh),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant)
  );

  // Reset gates the select so no buffer is popped while the arbiter is held.
  assign grant_c = any_grant & rst;
  assign sel     = rst ? grant_oh : '0;

  // Per-filter pair bundles; index slots beyond NUM_FILTER read as zero.
  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    if (g < NUM_FILTER) begin : g_live
      assign pair_slot[g] = {ref_particle_id_in[g*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH],
                             neighbor_particle_id_in[g*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH],
                             r2_in[g*DATA_WIDTH +: DATA_WIDTH],
                             dz_in[g*DATA_WIDTH +: DATA_WIDTH],
                             dy_in[g*DATA_WIDTH +: DATA_WIDTH],
                             dx_in[g*DATA_WIDTH +: DATA_WIDTH]};
    end else begin : g_pad
      assign pair_slot[g] = '0;
    end
  end

  // Grant bookkeeping and two-stage capture pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant    <= FILTER_SEL_WIDTH'(NUM_FILTER - 1);
      stage1_valid  <= 1'b0;
      stage1_idx    <= '0;
      pair_count    <= '0;
      out_valid     <= 1'b0;
      out_filter_id <= '0;
      pair_q        <= '0;
    end else begin
      stage1_valid <= grant_c;
      if (grant_c) begin
        last_grant <= grant_idx;
        stage1_idx <= grant_idx;
        pair_count <= pair_count + COUNT_WIDTH'(1);
      end
      out_valid <= stage1_valid;
      if (stage1_valid) begin
        pair_q        <= pair_slot[stage1_idx];
        out_filter_id <= stage1_idx;
      end
    end
  end

  assign dx                       = pair_q[0 +: DATA_WIDTH];
  assign dy                       = pair_q[DY_LSB +: DATA_WIDTH];
  assign dz                       = pair_q[DZ_LSB +: DATA_WIDTH];
  assign r2                       = pair_q[R2_LSB +: DATA_WIDTH];
  assign neighbor_particle_id_out = pair_q[NBR_LSB +: PARTICLE_ID_WIDTH];
  assign ref_particle_id_out      = pair_q[REF_LSB +: PARTICLE_ID_WIDTH];

endmodule

// File: tb/tb_filter_arbiter.sv
// Directed bench for filter_arbiter (4 filters, 4-bit pair counter).
module tb_filter_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 20;
  localparam int unsigned NF = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned BW = 2 * PW + 4 * DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NF-1:0]     avail;
  logic [NF-1:0]     sel;
  logic [NF*PW-1:0]  ref_in, nbr_in;
  logic [NF*DW-1:0]  r2_in, dx_in, dy_in, dz_in;
  logic              stall;
  logic [PW-1:0]     ref_out, nbr_out;
  logic [DW-1:0]     r2, dx, dy, dz;
  logic              out_valid;
  logic [SW-1:0]     out_filter_id;
  logic [CW-1:0]     pair_count;
  logic [BW-1:0]     got_pair;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  filter_arbiter #(
    .DATA_WIDTH        (DW),
    .PARTICLE_ID_WIDTH (PW),
    .NUM_FILTER        (NF),
    .FILTER_SEL_WIDTH  (SW),
    .COUNT_WIDTH       (CW)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .particle_pair_available  (avail),
    .sel                      (sel),
    .ref_particle_id_in       (ref_in),
    .neighbor_particle_id_in  (nbr_in),
    .r2_in                    (r2_in),
    .dx_in                    (dx_in),
    .dy_in                    (dy_in),
    .dz_in                    (dz_in),
    .out_stall                (stall),
    .ref_particle_id_out      (ref_out),
    .neighbor_particle_id_out (nbr_out),
    .r2                       (r2),
    .dx                       (dx),
    .dy                       (dy),
    .dz                       (dz),
    .out_valid                (out_valid),
    .out_filter_id            (out_filter_id),
    .pair_count               (pair_count)
  );

  assign got_pair = {ref_out, nbr_out, r2, dz, dy, dx};

  // Expected bundle for filter i, in {ref, nbr, r2, dz, dy, dx} order.
  function automatic logic [BW-1:0] exp_pair(input int unsigned i);
    logic [PW-1:0] r_id, n_id;
    r_id = PW'(32'hA0000 + i);
    n_id = PW'(32'hB0000 + i);
    return {r_id, n_id, 32'h3F80_0000 + i, 32'h3000_0000 + i,
            32'h2000_0000 + i, 32'h1000_0000 + i};
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    avail = '0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    avail = 4'b1111;
    stall = 1'b0;
    #1;
    n_total++;
    if (sel !== 4'b0000) $display("FAIL reset_sel: got %b want 0000", sel); else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if ({out_valid, out_filter_id, pair_count} !== '0)
      $display("FAIL reset_ctrl: got v=%b id=%0d cnt=%0d want all 0", out_valid, out_filter_id, pair_count);
    else n_pass++;
    n_total++;
    if (got_pair !== '0) $display("FAIL reset_data: got %h want 0", got_pair); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    avail = 4'b0100;
    #1;
    n_total++;
    if (sel !== 4'b0100) $display("FAIL single_sel: got %b want 0100", sel); else n_pass++;
    next_cyc();
    avail = 4'b0000;
    #1;
    n_total++;
    if ({sel, out_valid} !== 5'b0000_0)
      $display("FAIL single_idle: got sel=%b v=%b want sel=0000 v=0", sel, out_valid);
    else n_pass++;
    next_cyc();
    #1;
    n_total++;
    if ({out_valid, out_filter_id, pair_count} !== {1'b1, 2'd2, 4'd1})
      $display("FAIL single_out: got v=%b id=%0d cnt=%0d want v=1 id=2 cnt=1", out_valid, out_filter_id, pair_count);
    else n_pass++;
    n_total++;
    if (got_pair !== exp_pair(2)) $display("FAIL single_data: got %h want %h", got_pair, exp_pair(2)); else n_pass++;
    next_cyc();
    #1;
    n_total++;
    if (out_valid !== 1'b0 || got_pair !== exp_pair(2))
      $display("FAIL single_hold: got v=%b data=%h want v=0 data=%h", out_valid, got_pair, exp_pair(2));
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [NF-1:0] exp_sel;
    do_reset();
    avail = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_sel = NF'(1) << (k % 4);
      n_total++;
      if (sel !== exp_sel) $display("FAIL rr_sel[%0d]: got %b want %b", k, sel, exp_sel); else n_pass++;
      if (k >= 2) begin
        n_total++;
        if (out_valid !== 1'b1 || out_filter_id !== SW'((k - 2) % 4) || got_pair !== exp_pair((k - 2) % 4))
          $display("FAIL rr_out[%0d]: got v=%b id=%0d want v=1 id=%0d", k, out_valid, out_filter_id, (k - 2) % 4);
        else n_pass++;
      end
      next_cyc();
    end
    avail = 4'b0000;
    #1;
    n_total++;
    if (pair_count !== 4'd8) $display("FAIL rr_count: got %0d want 8", pair_count); else n_pass++;
  endtask

  task automatic test_alternate();
    logic [NF-1:0] exp_sel;
    do_reset();
    avail = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_sel = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      n_total++;
      if (sel !== exp_sel) $display("FAIL alt_sel[%0d]: got %b want %b", k, sel, exp_sel); else n_pass++;
      next_cyc();
    end
    avail = 4'b0000;
  endtask

  task automatic test_stall();
    logic [NF-1:0] exp_sel [10];
    logic          exp_v   [10];
    int            exp_id  [10];
    exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    exp_v   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_id  = '{0, 0, 0, 1, 2, 0, 0, 0, 3, 0};
    do_reset();
    avail = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      stall = (k >= 3 && k <= 5);
      #1;
      n_total++;
      if (sel !== exp_sel[k]) $display("FAIL stall_sel[%0d]: got %b want %b", k, sel, exp_sel[k]); else n_pass++;
      n_total++;
      if (out_valid !== exp_v[k] || (exp_v[k] && out_filter_id !== SW'(exp_id[k])))
        $display("FAIL stall_out[%0d]: got v=%b id=%0d want v=%b id=%0d", k, out_valid, out_filter_id, exp_v[k], exp_id[k]);
      else n_pass++;
      next_cyc();
    end
    stall = 1'b0;
    avail = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    avail = 4'b1111;
    repeat (3) next_cyc();
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL areset_pre: got v=%b want 1", out_valid); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_total++;
    if ({sel, out_valid, pair_count} !== '0 || got_pair !== '0)
      $display("FAIL areset_clear: got sel=%b v=%b cnt=%0d data=%h want all 0", sel, out_valid, pair_count, got_pair);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_total++;
    if ({sel, out_valid} !== 5'b0001_0)
      $display("FAIL areset_first: got sel=%b v=%b want sel=0001 v=0", sel, out_valid);
    else n_pass++;
    next_cyc();
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL areset_nopartial: got v=%b want 0", out_valid); else n_pass++;
    next_cyc();
    #1;
    n_total++;
    if (out_valid !== 1'b1 || out_filter_id !== 2'd0)
      $display("FAIL areset_out: got v=%b id=%0d want v=1 id=0", out_valid, out_filter_id);
    else n_pass++;
    avail = 4'b0000;
  endtask

  task automatic test_count_wrap();
    do_reset();
    avail = 4'b1111;
    repeat (17) next_cyc();
    #1;
    n_total++;
    if (pair_count !== 4'd1) $display("FAIL wrap_count: got %0d want 1", pair_count); else n_pass++;
    n_total++;
    if (sel !== 4'b0010) $display("FAIL wrap_sel: got %b want 0010", sel); else n_pass++;
    avail = 4'b0000;
  endtask

  initial begin
    rst   = 1'b0;
    avail = '0;
    stall = 1'b0;
    for (int i = 0; i < NF; i++) begin
      ref_in[i*PW +: PW] = PW'(32'hA0000 + i);
      nbr_in[i*PW +: PW] = PW'(32'hB0000 + i);
      r2_in[i*DW +: DW]  = 32'h3F80_0000 + i;
      dx_in[i*DW +: DW]  = 32'h1000_0000 + i;
      dy_in[i*DW +: DW]  = 32'h2000_0000 + i;
      dz_in[i*DW +: DW]  = 32'h3000_0000 + i;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_alternate();
    test_stall();
    test_async_reset();
    test_count_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
